// File: rtl/sipo_pkg.sv
// sipo_pkg
// Shared definitions for the serial-in/parallel-out deserializer:
//   - MSB_FIRST / LSB_FIRST : bit-order selector values
//   - MAX_WIDTH             : widest word the shift helper supports
//   - out_state_e           : output holding-register states
//   - shift_next()          : next shift-register value for one accepted bit
package sipo_pkg;

    localparam bit MSB_FIRST = 1'b1;
    localparam bit LSB_FIRST = 1'b0;
    localparam int MAX_WIDTH = 64;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Works on a zero-extended MAX_WIDTH container so one function serves
    // every WIDTH; the caller truncates the result back to its own width.
    // MSB-first shifts left and inserts at bit 0; LSB-first shifts right
    // and inserts at bit width-1.
    function automatic logic [MAX_WIDTH-1:0] shift_next(
        input logic [MAX_WIDTH-1:0] cur,
        input logic                 bit_in,
        input int unsigned          width,
        input logic                 msb_first
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] res;
        mask = (width >= MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        if (msb_first) begin
            res = (cur << 1) | 64'(bit_in);
        end else begin
            res = ((cur & mask) >> 1) | (64'(bit_in) << (width - 1));
        end
        return res & mask;
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core
// Shift register, bit counter and frame alignment. Never stalls.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_valid         : serial bit qualifier
//   i_serial        : serial data bit
//   i_frame_start   : realign; discards the partial word
//   o_word_done     : one-cycle pulse (combinational) on the completing edge
//   o_word          : completed word, valid while o_word_done is high
//   o_bit_count     : bits held in the current partial word
module sipo_shift_core #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int          CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_serial,
    input  logic             i_frame_start,
    output logic             o_word_done,
    output logic [WIDTH-1:0] o_word,
    output logic [CNT_W-1:0] o_bit_count
);
    import sipo_pkg::*;

    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_first_bit;
    logic             w_last;

    assign w_shift_next = WIDTH'(shift_next(64'(r_shift), i_serial, WIDTH, MSB_FIRST));
    // A frame_start bit starts a fresh word: shift it into an empty register.
    assign w_first_bit  = WIDTH'(shift_next(64'd0, i_serial, WIDTH, MSB_FIRST));
    assign w_last       = (r_count == CNT_W'(WIDTH - 1));

    // frame_start always wins over completion, even on the last bit slot.
    assign o_word_done  = i_valid && !i_frame_start && w_last;
    assign o_word       = w_shift_next;
    assign o_bit_count  = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_frame_start) begin
            if (i_valid) begin
                r_shift <= w_first_bit;
                r_count <= CNT_W'(1);
            end else begin
                r_shift <= '0;
                r_count <= '0;
            end
        end else if (i_valid) begin
            r_shift <= w_shift_next;
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer
// Serial-in/parallel-out deserializer with selectable bit order, frame
// alignment, a one-entry valid/ready output register and a sticky overrun.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   in_valid       : serial_in is sampled only when high
//   serial_in      : serial data bit
//   frame_start    : word alignment marker
//   out_data       : completed word (flop)
//   out_valid      : out_data holds an unconsumed word (flop)
//   out_ready      : consumer takes out_data on out_valid && out_ready
//   overrun        : sticky, a completed word was dropped
//   clear_overrun  : clears overrun (a simultaneous set wins)
//   bit_count      : bits in the current partial word
//
// Handshake: a word transfers on any rising edge where out_valid && out_ready.
// out_valid never depends combinationally on out_ready, and out_data only
// changes when a new word is loaded.
module sipo_deserializer #(
    parameter  int unsigned WIDTH     = 8,
    parameter  bit          MSB_FIRST = 1'b1,
    localparam int          CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             serial_in,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clear_overrun,
    output logic [CNT_W-1:0] bit_count
);
    import sipo_pkg::*;

    out_state_e       r_state;
    out_state_e       w_next_state;
    logic [WIDTH-1:0] r_data;
    logic             r_overrun;
    logic             w_load;
    logic             w_set_ovr;
    logic             w_word_done;
    logic [WIDTH-1:0] w_word;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_core (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (in_valid),
        .i_serial      (serial_in),
        .i_frame_start (frame_start),
        .o_word_done   (w_word_done),
        .o_word        (w_word),
        .o_bit_count   (bit_count)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_set_ovr    = 1'b0;
        case (r_state)
            OUT_EMPTY: begin
                if (w_word_done) begin
                    w_load       = 1'b1;
                    w_next_state = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (w_word_done && out_ready) begin
                    // Old word leaves as the new one arrives.
                    w_load = 1'b1;
                end else if (w_word_done) begin
                    // Nowhere to put the new word: drop it, keep the old one.
                    w_set_ovr = 1'b1;
                end else if (out_ready) begin
                    w_next_state = OUT_EMPTY;
                end
            end
            default: w_next_state = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= OUT_EMPTY;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_data <= w_word;
            end
            if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // out_valid is a direct decode of the one-bit state flop.
    assign out_valid = (r_state == OUT_FULL);
    assign out_data  = r_data;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          serial_in = 1'b0;
    logic          frame_start = 1'b0;
    logic          out_ready = 1'b0;
    logic          clear_overrun = 1'b0;

    logic [W-1:0]  out_data_m, out_data_l;
    logic          out_valid_m, out_valid_l;
    logic          overrun_m, overrun_l;
    logic [CW-1:0] bit_count_m, bit_count_l;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .serial_in(serial_in),
        .frame_start(frame_start), .out_data(out_data_m), .out_valid(out_valid_m),
        .out_ready(out_ready), .overrun(overrun_m), .clear_overrun(clear_overrun),
        .bit_count(bit_count_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .serial_in(serial_in),
        .frame_start(frame_start), .out_data(out_data_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .overrun(overrun_l), .clear_overrun(clear_overrun),
        .bit_count(bit_count_l)
    );

    // ---------------- reference model ----------------
    // Word-level view: a list of bits received since the last boundary, a
    // holding slot with a full flag, and a sticky drop flag.
    bit           m_bits[$];
    logic [W-1:0] m_data_m = '0;
    logic [W-1:0] m_data_l = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr = 1'b0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] assemble(input bit msb);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb) w[W-1-i] = m_bits[i];
            else     w[i]     = m_bits[i];
        end
        return w;
    endfunction

    task automatic model_step();
        bit           done;
        bit           set;
        logic [W-1:0] wm, wl;
        done = 0; set = 0; wm = '0; wl = '0;
        if (rst) begin
            m_bits.delete();
            m_data_m = '0; m_data_l = '0;
            m_valid = 1'b0; m_ovr = 1'b0;
            exp_q.delete();
            return;
        end
        if (frame_start) begin
            m_bits.delete();
            if (in_valid) m_bits.push_back(serial_in);
        end else if (in_valid) begin
            m_bits.push_back(serial_in);
            if (m_bits.size() == W) begin
                done = 1;
                wm = assemble(1'b1);
                wl = assemble(1'b0);
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || out_ready) begin
                m_data_m = wm; m_data_l = wl; m_valid = 1'b1;
                exp_q.push_back(wm);
            end else begin
                set = 1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (set) m_ovr = 1'b1;
        else if (clear_overrun) m_ovr = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Scoreboard: at the falling edge before each rising edge, a visible
    // handshake must consume the oldest expected word.
    task automatic tick();
        @(negedge clk);
        if (!rst && out_valid_m && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_unexpected_word: got %h, expected no word", out_data_m);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (out_data_m !== e) begin
                    n_err++;
                    $display("FAIL scoreboard_word: got %h, expected %h", out_data_m, e);
                end
            end
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
        out_ready = 1'b0; clear_overrun = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_word(output logic [W-1:0] w, input bit ready_last);
        w = '0;
        for (int i = 0; i < W; i++) begin
            in_valid = 1'b1;
            serial_in = 1'($urandom_range(0, 1));
            if (i == W - 1 && ready_last) out_ready = 1'b1;
            w = {w[W-2:0], serial_in};
            tick();
        end
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; serial_in = 1'b1; frame_start = 1'b0;
        out_ready = 1'b1; clear_overrun = 1'b0;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if ({out_data_m, out_valid_m, overrun_m, bit_count_m} !== '0 ||
            {out_data_l, out_valid_l, overrun_l, bit_count_l} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got m=%h/%b/%b/%0d l=%h/%b/%b/%0d, expected all zero",
                     out_data_m, out_valid_m, overrun_m, bit_count_m,
                     out_data_l, out_valid_l, overrun_l, bit_count_l);
        end
    endtask

    task automatic test_bit_order();
        logic [7:0] pat;
        pat = 8'b1011_0010;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            serial_in = pat[7-i];
            tick();
            if (i < 7) begin
                n_cmp++;
                if (out_valid_m !== 1'b0) begin
                    n_err++;
                    $display("FAIL order_early_valid: bit %0d got %b, expected 0", i, out_valid_m);
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid_m !== 1'b1 || out_data_m !== 8'hB2) begin
            n_err++;
            $display("FAIL order_msb_word: got %b/%h, expected 1/b2", out_valid_m, out_data_m);
        end
        n_cmp++;
        if (out_valid_l !== 1'b1 || out_data_l !== 8'h4D) begin
            n_err++;
            $display("FAIL order_lsb_word: got %b/%h, expected 1/4d", out_valid_l, out_data_l);
        end
        tick();
        n_cmp++;
        if (out_valid_m !== 1'b0 || out_valid_l !== 1'b0) begin
            n_err++;
            $display("FAIL order_one_cycle_valid: got %b/%b, expected 0/0", out_valid_m, out_valid_l);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_frame_align();
        logic [W-1:0] w;
        int           n_valid;
        do_reset();
        out_ready = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; serial_in = 1'($urandom_range(0, 1));
            tick();
            if (out_valid_m) n_valid++;
        end
        frame_start = 1'b1; serial_in = 1'($urandom_range(0, 1));
        w = {{(W-1){1'b0}}, serial_in};
        tick();
        frame_start = 1'b0;
        if (out_valid_m) n_valid++;
        n_cmp++;
        if (bit_count_m !== CW'(1)) begin
            n_err++;
            $display("FAIL frame_bit_count: got %0d, expected 1", bit_count_m);
        end
        for (int i = 0; i < W - 1; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            w = {w[W-2:0], serial_in};
            tick();
            if (out_valid_m) n_valid++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid_m !== 1'b1 || out_data_m !== w) begin
            n_err++;
            $display("FAIL frame_word: got %b/%h, expected 1/%h", out_valid_m, out_data_m, w);
        end
        tick();
        n_cmp++;
        if (n_valid !== 1 || out_valid_m !== 1'b0) begin
            n_err++;
            $display("FAIL frame_word_count: got %0d words (valid now %b), expected 1 (0)", n_valid, out_valid_m);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overrun();
        logic [W-1:0] w1, w2;
        do_reset();
        send_word(w1, 1'b0);
        send_word(w2, 1'b0);
        n_cmp++;
        if (out_data_m !== w1 || out_valid_m !== 1'b1 || overrun_m !== 1'b1 || overrun_l !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set: got %h/%b/%b/%b, expected %h/1/1/1 (dropped %h)",
                     out_data_m, out_valid_m, overrun_m, overrun_l, w1, w2);
        end
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        n_cmp++;
        if (overrun_m !== 1'b0 || out_data_m !== w1 || out_valid_m !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_clear: got %b/%h/%b, expected 0/%h/1", overrun_m, out_data_m, out_valid_m, w1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid_m !== 1'b0 || out_data_m !== w1) begin
            n_err++;
            $display("FAIL overrun_drain: got %b/%h, expected 0/%h", out_valid_m, out_data_m, w1);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1, w2;
        do_reset();
        send_word(w1, 1'b0);
        send_word(w2, 1'b1);
        out_ready = 1'b0;
        n_cmp++;
        if (out_data_m !== w2 || out_valid_m !== 1'b1 || overrun_m !== 1'b0) begin
            n_err++;
            $display("FAIL same_edge_replace: got %h/%b/%b, expected %h/1/0 (first %h)",
                     out_data_m, out_valid_m, overrun_m, w2, w1);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] w;
        do_reset();
        send_word(w, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; serial_in = 1'($urandom_range(0, 1));
            tick();
        end
        n_cmp++;
        if (bit_count_m !== CW'(5) || out_valid_m !== 1'b1) begin
            n_err++;
            $display("FAIL midword_pre: got count %0d valid %b, expected 5/1", bit_count_m, out_valid_m);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if ({out_data_m, out_valid_m, overrun_m, bit_count_m} !== '0) begin
            n_err++;
            $display("FAIL midword_reset: got %h/%b/%b/%0d, expected all zero",
                     out_data_m, out_valid_m, overrun_m, bit_count_m);
        end
        out_ready = 1'b1;
        send_word(w, 1'b0);
        n_cmp++;
        if (out_data_m !== w || out_valid_m !== 1'b1) begin
            n_err++;
            $display("FAIL midword_clean_word: got %h/%b, expected %h/1", out_data_m, out_valid_m, w);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int ready_pct;
        do_reset();
        ready_pct = 80;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) ready_pct = int'($urandom_range(0, 100));
            rst           = ($urandom_range(0, 399) == 0);
            in_valid      = ($urandom_range(0, 3) != 0);
            serial_in     = 1'($urandom_range(0, 1));
            frame_start   = ($urandom_range(0, 24) == 0);
            out_ready     = (int'($urandom_range(0, 99)) < ready_pct);
            clear_overrun = ($urandom_range(0, 15) == 0);
            tick();
            n_cmp++;
            if (out_data_m !== m_data_m || out_valid_m !== m_valid) begin
                n_err++;
                $display("FAIL rand_msb cyc %0d: got %h/%b, expected %h/%b", c, out_data_m, out_valid_m, m_data_m, m_valid);
            end
            n_cmp++;
            if (out_data_l !== m_data_l || out_valid_l !== m_valid) begin
                n_err++;
                $display("FAIL rand_lsb cyc %0d: got %h/%b, expected %h/%b", c, out_data_l, out_valid_l, m_data_l, m_valid);
            end
            n_cmp++;
            if (overrun_m !== m_ovr || overrun_l !== m_ovr) begin
                n_err++;
                $display("FAIL rand_overrun cyc %0d: got %b/%b, expected %b", c, overrun_m, overrun_l, m_ovr);
            end
            n_cmp++;
            if (bit_count_m !== CW'(m_bits.size()) || bit_count_l !== CW'(m_bits.size())) begin
                n_err++;
                $display("FAIL rand_bit_count cyc %0d: got %0d/%0d, expected %0d", c, bit_count_m, bit_count_l, m_bits.size());
            end
        end
        rst = 1'b0; in_valid = 1'b0; frame_start = 1'b0;
        out_ready = 1'b0; clear_overrun = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_bit_order();
        test_frame_align();
        test_overrun();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
